div_clk_monitor: RTL and testbench

- Sits directly downstream of the even clock divider. Checks the divider's three outputs (clk_div2, clk_div4, clk_div10) by sampling them in the source clock domain.
- Each channel measures every half-period in clk cycles and compares it with the expected value.
- Reports per-channel lock, a one-cycle error pulse, and a sticky error. Feeds status/interrupt logic and gates use of the divided clocks until they are locked.

---
 rtl/div_clk_monitor.sv | 151 +++++++++++++++
 tb/tb_div_clk_monitor.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: samples the three even-divider outputs in the source clock
// domain, measures every half-period and reports per-channel lock and errors.
module div_clk_monitor #(
    parameter int unsigned EXP2     = 1,
    parameter int unsigned EXP4     = 2,
    parameter int unsigned EXP10    = 5,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CW       = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       clk_div2,
    input  logic       clk_div4,
    input  logic       clk_div10,
    input  logic       err_clr,
    output logic [2:0] locked,
    output logic [2:0] err_pulse,
    output logic [2:0] err_sticky,
    output logic       all_locked
);

    localparam int unsigned NCH = 3;
    localparam int unsigned GW  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    logic [NCH-1:0] div_in;
    logic [NCH-1:0] s1;
    logic [NCH-1:0] s2;
    logic [NCH-1:0] edge_seen;
    logic [NCH-1:0] lock_nxt;
    logic [NCH-1:0] err_nxt;

    assign div_in    = {clk_div10, clk_div4, clk_div2};
    assign edge_seen = s1 ^ s2;

    // Two-stage sampling of the divider outputs; keeps running while disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= div_in;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
        localparam int unsigned EXP = (i == 0) ? EXP2 : ((i == 1) ? EXP4 : EXP10);

        state_t          state;
        state_t          state_nxt;
        logic [CW-1:0]   run_cnt;
        logic [CW-1:0]   run_nxt;
        logic [GW-1:0]   good_cnt;
        logic [GW-1:0]   good_nxt;
        logic [GW-1:0]   good_inc;
        logic            err;

        // Channel state, run counter and good-half-period counter.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state    <= IDLE;
                run_cnt  <= '0;
                good_cnt <= '0;
            end else begin
                state    <= state_nxt;
                run_cnt  <= run_nxt;
                good_cnt <= good_nxt;
            end
        end

        // Half-period measurement, lock tracking and error detection.
        always_comb begin
            state_nxt = state;
            run_nxt   = run_cnt;
            good_nxt  = good_cnt;
            err       = 1'b0;
            good_inc  = (good_cnt < GW'(LOCK_CNT)) ? good_cnt + GW'(1) : good_cnt;

            if (edge_seen[i]) begin
                run_nxt = CW'(1);
            end else if (run_cnt != {CW{1'b1}}) begin
                run_nxt = run_cnt + CW'(1);
            end

            if (!en) begin
                state_nxt = IDLE;
                run_nxt   = '0;
                good_nxt  = '0;
            end else begin
                case (state)
                    IDLE: begin
                        // First edge only arms the channel; it is never measured.
                        if (edge_seen[i]) begin
                            state_nxt = MEASURE;
                            good_nxt  = '0;
                        end
                    end
                    MEASURE, LOCKED: begin
                        if (edge_seen[i]) begin
                            if (run_cnt == CW'(EXP)) begin
                                good_nxt = good_inc;
                                if (good_inc == GW'(LOCK_CNT)) begin
                                    state_nxt = LOCKED;
                                end
                            end else begin
                                err = 1'b1;
                            end
                        end else if (run_cnt > CW'(EXP)) begin
                            // Overrun without an edge: flag stuck input right away.
                            err = 1'b1;
                        end
                        if (err) begin
                            state_nxt = MEASURE;
                            good_nxt  = '0;
                            run_nxt   = CW'(1);
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                    end
                endcase
            end
        end

        assign lock_nxt[i] = (state_nxt == LOCKED);
        assign err_nxt[i]  = err;
    end

    // Registered status outputs; a new error wins over err_clr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            locked     <= '0;
            all_locked <= 1'b0;
            err_pulse  <= '0;
            err_sticky <= '0;
        end else begin
            locked     <= lock_nxt;
            all_locked <= &lock_nxt;
            err_pulse  <= err_nxt;
            err_sticky <= (err_sticky & ~{NCH{err_clr}}) | err_nxt;
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: drives div_clk_monitor from a behavioural divider with
// per-channel period, stuck and skip controls; checks against a timestamp model.
module tb_div_clk_monitor;

    localparam int EXPV [3] = '{1, 2, 5};
    localparam int LOCKN    = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b1;
    logic       err_clr = 1'b0;
    logic [2:0] locked;
    logic [2:0] err_pulse;
    logic [2:0] err_sticky;
    logic       all_locked;

    // Divider stand-in
    logic [2:0] div_q = 3'b000;
    int         gcnt [3] = '{0, 0, 0};
    int         hp [3] = '{1, 2, 5};
    int         tog [3] = '{0, 0, 0};
    logic [2:0] stuck = 3'b000;
    int         hold_req [3] = '{0, 0, 0};
    int         hold_done [3] = '{0, 0, 0};

    // Model state
    logic [2:0] cur_m = 3'b000;
    logic [2:0] prv_m = 3'b000;
    int         cyc_m = 0;
    logic       armed [3];
    int         good_m [3];
    logic       lk_m [3];
    int         ref_m [3];
    logic [2:0] pls_m;
    logic [2:0] exp_locked = 3'b000;
    logic [2:0] exp_pulse = 3'b000;
    logic [2:0] exp_sticky = 3'b000;
    logic       exp_all = 1'b0;
    int         len_m;
    logic       e_m;
    logic       bad_m;

    int n_chk = 0;
    int n_fail = 0;

    // Directed-test scratch
    logic [2:0] seen;
    int         last_p;
    int         npulse;
    logic       gap_bad;
    logic       others_bad;
    logic       wp_lk;
    int         wp_cnt;
    int         nwait;

    div_clk_monitor dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .clk_div2   (div_q[0]),
        .clk_div4   (div_q[1]),
        .clk_div10  (div_q[2]),
        .err_clr    (err_clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .all_locked (all_locked)
    );

    always #5 clk = ~clk;

    // Divider: toggles each channel every hp cycles, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                div_q = 3'b000;
                for (int k = 0; k < 3; k++) gcnt[k] = 0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (stuck[k]) begin
                        div_q[k] = 1'b0;
                    end else if (hold_req[k] != hold_done[k]) begin
                        hold_done[k] = hold_req[k];
                    end else begin
                        gcnt[k]++;
                        if (gcnt[k] >= hp[k]) begin
                            div_q[k] = ~div_q[k];
                            gcnt[k]  = 0;
                            tog[k]++;
                        end
                    end
                end
            end
        end
    end

    // Model: timestamps of the last reference event per channel; a level
    // change seen in cycle c has length c - ref, too long without a change is stuck.
    initial begin
        for (int k = 0; k < 3; k++) begin
            armed[k] = 1'b0; good_m[k] = 0; lk_m[k] = 1'b0; ref_m[k] = 0;
        end
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                cur_m = 3'b000; prv_m = 3'b000; cyc_m = 0;
                for (int k = 0; k < 3; k++) begin
                    armed[k] = 1'b0; good_m[k] = 0; lk_m[k] = 1'b0; ref_m[k] = 0;
                end
                exp_locked = 3'b000; exp_pulse = 3'b000; exp_sticky = 3'b000; exp_all = 1'b0;
            end else begin
                pls_m = 3'b000;
                for (int k = 0; k < 3; k++) begin
                    e_m = cur_m[k] ^ prv_m[k];
                    if (!en) begin
                        armed[k] = 1'b0; good_m[k] = 0; lk_m[k] = 1'b0;
                    end else if (!armed[k]) begin
                        if (e_m) begin
                            armed[k] = 1'b1; good_m[k] = 0; ref_m[k] = cyc_m;
                        end
                    end else begin
                        len_m = cyc_m - ref_m[k];
                        bad_m = e_m ? (len_m != EXPV[k]) : (len_m > EXPV[k]);
                        if (bad_m) begin
                            pls_m[k] = 1'b1; good_m[k] = 0; lk_m[k] = 1'b0; ref_m[k] = cyc_m;
                        end else if (e_m) begin
                            if (good_m[k] < LOCKN) good_m[k]++;
                            if (good_m[k] == LOCKN) lk_m[k] = 1'b1;
                            ref_m[k] = cyc_m;
                        end
                    end
                end
                exp_sticky = (exp_sticky & ~{3{err_clr}}) | pls_m;
                exp_pulse  = pls_m;
                exp_locked = {lk_m[2], lk_m[1], lk_m[0]};
                exp_all    = &exp_locked;
                prv_m = cur_m;
                cur_m = div_q;
                cyc_m++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge: outputs {locked, err_pulse, err_sticky, all_locked} vs model.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("model", {22'b0, locked, err_pulse, err_sticky, all_locked},
                  {22'b0, exp_locked, exp_pulse, exp_sticky, exp_all});
        end
    endtask

    task automatic wait_lock(input string name, input int budget, output logic [2:0] pul);
        int n;
        n = 0;
        pul = 3'b000;
        while (!(locked == 3'b111 && all_locked) && n < budget) begin
            @(posedge clk); #1;
            pul = pul | err_pulse;
            n++;
        end
        check(name, 32'(locked == 3'b111 && all_locked), 32'd1);
    endtask

    task automatic wait_tog(input int k);
        int t0;
        int n;
        t0 = tog[k];
        n = 0;
        while (tog[k] == t0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        check("tog_wait", 32'(tog[k] != t0), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {22'b0, locked, err_pulse, err_sticky, all_locked}, 32'd0);
        fork
            compare_loop();
        join_none
        rstn = 1'b1;

        // Initial lock from the divider
        wait_lock("lock_initial", 32, seen);
        check("lock_no_pulse", 32'(seen), 32'd0);

        // One half-period of 6 on clk_div10
        wait_tog(2);
        hp[2] = 6;
        wait_tog(2);
        hp[2] = 5;
        wp_cnt = 0; wp_lk = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (err_pulse[2]) begin
                wp_cnt++;
                wp_lk = locked[2];
            end
        end
        check("wp_pulse_count", 32'(wp_cnt), 32'd1);
        check("wp_locked_drop", 32'(wp_lk), 32'd0);
        check("wp_sticky_set", 32'(err_sticky), 32'd4);
        nwait = 0;
        while (!locked[2] && nwait < 40) begin
            @(posedge clk); #1; nwait++;
        end
        check("wp_relock", 32'(locked[2]), 32'd1);
        check("wp_sticky_hold", 32'(err_sticky), 32'd4);

        // Plain clear
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("clr_sticky", 32'(err_sticky), 32'd0);

        // clk_div4 stuck low
        stuck[1] = 1'b1;
        last_p = -1; npulse = 0; gap_bad = 1'b0; others_bad = 1'b0;
        for (int n = 0; n < 24; n++) begin
            @(posedge clk); #1;
            if (err_pulse[1]) begin
                if (last_p >= 0 && n - last_p != 3) gap_bad = 1'b1;
                last_p = n;
                npulse++;
            end
            if (err_pulse[0] || err_pulse[2] || !locked[0] || !locked[2]) others_bad = 1'b1;
        end
        check("stuck_gap", 32'(gap_bad), 32'd0);
        check("stuck_count", 32'(npulse >= 6), 32'd1);
        check("stuck_locked1", 32'(locked[1]), 32'd0);
        check("stuck_others", 32'(others_bad), 32'd0);
        stuck[1] = 1'b0;
        wait_lock("stuck_relock", 40, seen);
        check("stuck_sticky", 32'(err_sticky), 32'd2);

        // Enable drop with sticky = 3'b010
        en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("en_locked", 32'({locked, all_locked}), 32'd0);
        check("en_sticky", 32'(err_sticky), 32'd2);
        en = 1'b1;
        wait_lock("en_relock", 40, seen);
        check("en_no_pulse", 32'(seen), 32'd0);

        // err_clr coinciding with a channel-0 error (one half-period of 2)
        hold_req[0]++;
        @(posedge clk);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        check("race_pulse", 32'(err_pulse), 32'd1);
        check("race_sticky", 32'(err_sticky), 32'd1);
        check("race_locked", 32'(locked), 32'd6);
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("clr_next", 32'(err_sticky), 32'd0);
        wait_lock("race_relock", 40, seen);

        // Reset mid-operation
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check("rst_async", {22'b0, locked, err_pulse, err_sticky, all_locked}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        wait_lock("rst_relock", 32, seen);
        check("rst_no_pulse", 32'(seen), 32'd0);

        // Long clean run
        repeat (1000) @(posedge clk);
        #1;
        check("long_sticky", 32'(err_sticky), 32'd0);
        check("long_locked", 32'(locked), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
